// File: rtl/mdio_request_arbiter_if.sv
// Bundle between MDIO requesters, the arbiter and the shared EthernetMDIOTransceiver.
// The master modport is the requester/transceiver side; slave is the arbiter.
interface mdio_request_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_rd;
    logic [NUM_REQ-1:0]    req_wr;
    logic [5*NUM_REQ-1:0]  req_md_addr;
    logic [5*NUM_REQ-1:0]  req_reg_addr;
    logic [16*NUM_REQ-1:0] req_wr_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  req_err;
    logic [15:0]           req_rd_data;
    logic [IDX_W-1:0]      grant_idx;
    logic [4:0]            phy_md_addr;
    logic [4:0]            phy_reg_addr;
    logic [15:0]           phy_wr_data;
    logic                  phy_reg_rd;
    logic                  phy_reg_wr;
    logic                  mgmt_busy;
    logic [15:0]           phy_rd_data;

    modport master (
        output req_rd, req_wr, req_md_addr, req_reg_addr, req_wr_data, mgmt_busy, phy_rd_data,
        input  req_ack, req_err, req_rd_data, grant_idx, phy_md_addr, phy_reg_addr, phy_wr_data,
        input  phy_reg_rd, phy_reg_wr
    );

    modport slave (
        input  req_rd, req_wr, req_md_addr, req_reg_addr, req_wr_data, mgmt_busy, phy_rd_data,
        output req_ack, req_err, req_rd_data, grant_idx, phy_md_addr, phy_reg_addr, phy_wr_data,
        output phy_reg_rd, phy_reg_wr
    );
endinterface

// File: rtl/mdio_request_arbiter.sv
// Round-robin arbiter sharing one MDIO transceiver between NUM_REQ requesters.
// Optional busy-wait timeout enabled by defining MDIO_ARB_TIMEOUT_EN.
module mdio_request_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mdio_request_arbiter_if.slave bus
);
    localparam int unsigned      IDX_W    = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
        $error("mdio_request_arbiter: unsupported NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {StIdle, StIssue, StGuard, StWait, StDone} state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic               op_wr_q;
    logic [4:0]         md_addr_q;
    logic [4:0]         reg_addr_q;
    logic [15:0]        wr_data_q;
    logic               strobe_rd_q;
    logic               strobe_wr_q;
    logic [NUM_REQ-1:0] ack_q;
    logic [15:0]        rd_data_q;
`ifdef MDIO_ARB_TIMEOUT_EN
    logic [31:0]        wait_cnt_q;
    logic               err_q;
`endif

    logic [NUM_REQ-1:0] active;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    int unsigned        cand;

    assign active = bus.req_rd | bus.req_wr;

    // Scan starts just after the last grant so the requester just served ranks last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = grant_q;
        cand       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(grant_q) + k) % NUM_REQ;
            if (!pick_valid && active[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= LAST_IDX;
            op_wr_q     <= 1'b0;
            md_addr_q   <= '0;
            reg_addr_q  <= '0;
            wr_data_q   <= '0;
            strobe_rd_q <= 1'b0;
            strobe_wr_q <= 1'b0;
            ack_q       <= '0;
            rd_data_q   <= '0;
`ifdef MDIO_ARB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            strobe_rd_q <= 1'b0;
            strobe_wr_q <= 1'b0;
            ack_q       <= '0;
`ifdef MDIO_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (!bus.mgmt_busy && pick_valid) begin
                        grant_q     <= pick_idx;
                        op_wr_q     <= bus.req_wr[pick_idx];
                        md_addr_q   <= bus.req_md_addr[5*int'(pick_idx) +: 5];
                        reg_addr_q  <= bus.req_reg_addr[5*int'(pick_idx) +: 5];
                        wr_data_q   <= bus.req_wr_data[16*int'(pick_idx) +: 16];
                        // Write wins when both rd and wr are held.
                        strobe_wr_q <= bus.req_wr[pick_idx];
                        strobe_rd_q <= ~bus.req_wr[pick_idx];
                        state_q     <= StIssue;
                    end
                end
                StIssue: state_q <= StGuard;
                StGuard: begin
`ifdef MDIO_ARB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q <= StWait;
                end
                StWait: begin
                    if (!bus.mgmt_busy) begin
                        rd_data_q      <= op_wr_q ? 16'h0000 : bus.phy_rd_data;
                        ack_q[grant_q] <= 1'b1;
                        state_q        <= StDone;
                    end
`ifdef MDIO_ARB_TIMEOUT_EN
                    else if (wait_cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
                        rd_data_q      <= 16'hFFFF;
                        ack_q[grant_q] <= 1'b1;
                        err_q          <= 1'b1;
                        state_q        <= StDone;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
`endif
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ack      = ack_q;
    assign bus.req_rd_data  = rd_data_q;
    assign bus.grant_idx    = grant_q;
    assign bus.phy_md_addr  = md_addr_q;
    assign bus.phy_reg_addr = reg_addr_q;
    assign bus.phy_wr_data  = wr_data_q;
    assign bus.phy_reg_rd   = strobe_rd_q;
    assign bus.phy_reg_wr   = strobe_wr_q;
`ifdef MDIO_ARB_TIMEOUT_EN
    assign bus.req_err      = err_q;
`else
    assign bus.req_err      = 1'b0;
`endif
endmodule

// File: tb/tb_mdio_request_arbiter.sv
// Scoreboard bench for mdio_request_arbiter with a simple transceiver busy model.
// Timeout scenario runs only when MDIO_ARB_TIMEOUT_EN is defined.
module tb_mdio_request_arbiter;
    typedef struct packed {
        logic        wr;
        logic [4:0]  md;
        logic [4:0]  rg;
        logic [15:0] wd;
    } strobe_t;

    typedef struct packed {
        logic [1:0]  ack;
        logic [15:0] data;
        logic        err;
    } ack_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mdio_request_arbiter_if #(.NUM_REQ(2)) bus ();

    mdio_request_arbiter #(
        .NUM_REQ       (2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    strobe_t     strobe_q[$];
    ack_t        ack_q[$];
    int          passed = 0;
    int          total = 0;
    int          strobe_cnt = 0;
    int          ack_cnt = 0;
    int          cyc = 0;
    int          last_strobe_cyc = 0;
    int          last_ack_cyc = 0;
    int          busy_len = 4;
    int          busy_cnt = 0;
    logic        model_busy = 1'b0;
    logic        ext_busy = 1'b0;
    logic [15:0] model_rd_data = 16'h0000;

    assign bus.mgmt_busy   = model_busy | ext_busy;
    assign bus.phy_rd_data = model_rd_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic exp_strobe(input logic wr, input logic [4:0] md, input logic [4:0] rg,
                              input logic [15:0] wd);
        strobe_t s;
        s.wr = wr; s.md = md; s.rg = rg; s.wd = wd;
        strobe_q.push_back(s);
    endtask

    task automatic exp_ack(input logic [1:0] ack, input logic [15:0] data, input logic err);
        ack_t a;
        a.ack = ack; a.data = data; a.err = err;
        ack_q.push_back(a);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Transceiver model: goes busy right after a strobe for busy_len cycles; also checks strobes.
    initial forever begin
        @(posedge clk);
        #1;
        if (bus.phy_reg_rd || bus.phy_reg_wr) begin
            strobe_t e;
            strobe_cnt++;
            last_strobe_cyc = cyc;
            check("strobe_onehot", 32'(bus.phy_reg_rd & bus.phy_reg_wr), 32'd0);
            check("strobe_expected", 32'(strobe_q.size() != 0), 32'd1);
            if (strobe_q.size() != 0) begin
                e = strobe_q.pop_front();
                check("strobe_is_wr", 32'(bus.phy_reg_wr), 32'(e.wr));
                check("phy_md_addr", 32'(bus.phy_md_addr), 32'(e.md));
                check("phy_reg_addr", 32'(bus.phy_reg_addr), 32'(e.rg));
                check("phy_wr_data", 32'(bus.phy_wr_data), 32'(e.wd));
            end
            model_busy = 1'b1;
            busy_cnt   = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) model_busy = 1'b0;
        end
    end

    // Ack monitor: compares every presented completion against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.req_ack != 2'b00) begin
            ack_t e;
            ack_cnt++;
            last_ack_cyc = cyc;
            check("ack_expected", 32'(ack_q.size() != 0), 32'd1);
            if (ack_q.size() != 0) begin
                e = ack_q.pop_front();
                check("req_ack", 32'(bus.req_ack), 32'(e.ack));
                check("req_rd_data", 32'(bus.req_rd_data), 32'(e.data));
                check("req_err", 32'(bus.req_err), 32'(e.err));
            end
        end
    end

    task automatic set_req(input int i, input logic wr, input logic [4:0] md,
                           input logic [4:0] rg, input logic [15:0] wd);
        bus.req_md_addr[5*i +: 5]   = md;
        bus.req_reg_addr[5*i +: 5]  = rg;
        bus.req_wr_data[16*i +: 16] = wd;
        bus.req_wr[i] = wr;
        bus.req_rd[i] = ~wr;
    endtask

    // Holds requester i until it has seen n acks, then drops in the last ack cycle.
    task automatic requester(input int i, input int n);
        int got = 0;
        int budget = 3000;
        while (got < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.req_ack[i]) got++;
        end
        check($sformatf("acks_seen_req%0d", i), 32'(got), 32'(n));
        bus.req_rd[i] = 1'b0;
        bus.req_wr[i] = 1'b0;
    endtask

    task automatic do_reset();
        int b = 500;
        bus.req_rd = '0;
        bus.req_wr = '0;
        ext_busy   = 1'b0;
        while (model_busy && b > 0) begin
            @(negedge clk);
            b--;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(bus.req_ack), 32'd0);
        check({tag, "_rd_strobe"}, 32'(bus.phy_reg_rd), 32'd0);
        check({tag, "_wr_strobe"}, 32'(bus.phy_reg_wr), 32'd0);
        check({tag, "_md_addr"}, 32'(bus.phy_md_addr), 32'd0);
        check({tag, "_reg_addr"}, 32'(bus.phy_reg_addr), 32'd0);
        check({tag, "_wr_data"}, 32'(bus.phy_wr_data), 32'd0);
        check({tag, "_rd_data"}, 32'(bus.req_rd_data), 32'd0);
        check({tag, "_err"}, 32'(bus.req_err), 32'd0);
        check({tag, "_grant_idx"}, 32'(bus.grant_idx), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int a0;
        int b;
        bus.req_rd = '0;
        bus.req_wr = '0;
        bus.req_md_addr = '0;
        bus.req_reg_addr = '0;
        bus.req_wr_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single read.
        busy_len = 40;
        model_rd_data = 16'h796D;
        exp_strobe(1'b0, 5'h01, 5'h02, 16'h0000);
        exp_ack(2'b01, 16'h796D, 1'b0);
        set_req(0, 1'b0, 5'h01, 5'h02, 16'h0000);
        requester(0, 1);
        repeat (10) @(negedge clk);
        check("grant_after_single", 32'(bus.grant_idx), 32'd0);
        check("rd_data_holds", 32'(bus.req_rd_data), 32'h796D);

        // Simultaneous write on 0 and read on 1.
        do_reset();
        busy_len = 5;
        model_rd_data = 16'h1234;
        exp_strobe(1'b1, 5'h03, 5'h04, 16'hA5A5);
        exp_strobe(1'b0, 5'h05, 5'h06, 16'h0F0F);
        exp_ack(2'b01, 16'h0000, 1'b0);
        exp_ack(2'b10, 16'h1234, 1'b0);
        set_req(0, 1'b1, 5'h03, 5'h04, 16'hA5A5);
        set_req(1, 1'b0, 5'h05, 5'h06, 16'h0F0F);
        fork
            requester(0, 1);
            requester(1, 1);
        join
        repeat (5) @(negedge clk);

        // Fairness with both held for 8 transactions.
        do_reset();
        busy_len = 3;
        model_rd_data = 16'hBEEF;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                exp_strobe(1'b0, 5'h07, 5'h08, 16'h0000);
                exp_ack(2'b01, 16'hBEEF, 1'b0);
            end else begin
                exp_strobe(1'b1, 5'h09, 5'h0A, 16'h5A5A);
                exp_ack(2'b10, 16'h0000, 1'b0);
            end
        end
        set_req(0, 1'b0, 5'h07, 5'h08, 16'h0000);
        set_req(1, 1'b1, 5'h09, 5'h0A, 16'h5A5A);
        fork
            requester(0, 4);
            requester(1, 4);
        join
        repeat (5) @(negedge clk);

        // Busy held externally before the request.
        do_reset();
        ext_busy = 1'b1;
        busy_len = 4;
        model_rd_data = 16'h0C0C;
        s0 = strobe_cnt;
        set_req(1, 1'b0, 5'h0B, 5'h0C, 16'h0000);
        repeat (20) @(negedge clk);
        check("no_strobe_while_busy", 32'(strobe_cnt - s0), 32'd0);
        exp_strobe(1'b0, 5'h0B, 5'h0C, 16'h0000);
        exp_ack(2'b10, 16'h0C0C, 1'b0);
        ext_busy = 1'b0;
        requester(1, 1);
        repeat (5) @(negedge clk);
        check("busy_start_one_strobe", 32'(strobe_cnt - s0), 32'd1);

        // Reset in the middle of WAIT.
        do_reset();
        busy_len = 50;
        model_rd_data = 16'h1111;
        a0 = ack_cnt;
        exp_strobe(1'b0, 5'h0D, 5'h0E, 16'h7777);
        set_req(0, 1'b0, 5'h0D, 5'h0E, 16'h7777);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwait");
        @(negedge clk);
        rst_n = 1'b1;
        s0 = strobe_cnt;
        b = 200;
        while (model_busy && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("busy_drop_seen", 32'(model_busy), 32'd0);
        check("no_reissue_while_busy", 32'(strobe_cnt - s0), 32'd0);
        check("no_ack_after_abort", 32'(ack_cnt - a0), 32'd0);
        model_rd_data = 16'h2222;
        busy_len = 3;
        exp_strobe(1'b0, 5'h0D, 5'h0E, 16'h7777);
        exp_ack(2'b01, 16'h2222, 1'b0);
        requester(0, 1);
        repeat (5) @(negedge clk);

`ifdef MDIO_ARB_TIMEOUT_EN
        // Busy stuck high: timeout after 100 WAIT cycles.
        do_reset();
        busy_len = 2;
        s0 = strobe_cnt;
        a0 = ack_cnt;
        exp_strobe(1'b0, 5'h0F, 5'h10, 16'h0000);
        exp_ack(2'b01, 16'hFFFF, 1'b1);
        set_req(0, 1'b0, 5'h0F, 5'h10, 16'h0000);
        b = 50;
        while (strobe_cnt == s0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        ext_busy = 1'b1;
        b = 500;
        while (ack_cnt == a0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        check("timeout_acked", 32'(ack_cnt - a0), 32'd1);
        check("timeout_latency", 32'(last_ack_cyc - last_strobe_cyc), 32'd102);
        s0 = strobe_cnt;
        repeat (20) @(negedge clk);
        check("no_strobe_after_timeout", 32'(strobe_cnt - s0), 32'd0);
        bus.req_rd = '0;
        ext_busy = 1'b0;
        repeat (5) @(negedge clk);
`endif

        repeat (10) @(negedge clk);
        check("idle_rd_strobe", 32'(bus.phy_reg_rd), 32'd0);
        check("idle_wr_strobe", 32'(bus.phy_reg_wr), 32'd0);
        check("strobe_queue_drained", 32'(strobe_q.size()), 32'd0);
        check("ack_queue_drained", 32'(ack_q.size()), 32'd0);
        check("strobe_count_eq_ack_count", 32'(strobe_cnt), 32'(ack_cnt + 1));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
